// File: rtl/bank_conflict_read_scheduler.sv
// -----------------------------------------------------------------------------
// bank_conflict_read_scheduler
//
// Purpose:
//   Sequences one warp's operand reads into the 32-bank register file. A request
//   carries a register bitmap and an active-thread mask. Each thread's bank set is
//   derived from the dispatcher register->bank mapping. The scheduler then emits
//   read beats until every active thread is served. Within a beat, no two
//   granted threads share a bank, and at most MAX_ISSUE threads are granted.
//
// Optional feature (macro BANK_SCHED_PERF_EN):
//   When defined, adds the saturating counters perf_beats (read handshakes) and
//   perf_conflict_beats (read handshakes that were not the final beat).
//   When undefined, those ports and counters are absent and scheduling is
//   unchanged.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_reg_bitmap        registers read by the instruction (bit i = reg i)
//   req_tmask             active threads of the warp
//   req_tag               opaque tag, returned on every beat
//   rd_valid/rd_ready     read-beat handshake
//   rd_tmask              threads granted this beat
//   rd_bank_bitmap        union of the granted threads' bank sets
//   rd_last               final beat of the request
//   rd_tag                latched request tag
//   perf_beats            (BANK_SCHED_PERF_EN) count of read handshakes
//   perf_conflict_beats   (BANK_SCHED_PERF_EN) count of non-final handshakes
//   busy                  request in flight
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request, req_ready=1
// SCHED   | presenting beats from the pending mask until rd_last is taken
// -----------------------------------------------------------------------------
module bank_conflict_read_scheduler #(
    parameter int NUM_THREADS = 32,
    parameter int MAX_ISSUE   = 8,
    parameter int TAG_W       = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_reg_bitmap,
    input  logic [NUM_THREADS-1:0] req_tmask,
    input  logic [TAG_W-1:0]       req_tag,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [NUM_THREADS-1:0] rd_tmask,
    output logic [31:0]            rd_bank_bitmap,
    output logic                   rd_last,
    output logic [TAG_W-1:0]       rd_tag,
`ifdef BANK_SCHED_PERF_EN
    output logic [31:0]            perf_beats,
    output logic [31:0]            perf_conflict_beats,
`endif
    output logic                   busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SCHED = 1'b1;

    logic [0:0]             state;
    logic [NUM_THREADS-1:0] pending;
    logic [31:0]            reg_bitmap_q;
    logic [TAG_W-1:0]       tag_q;

    logic [31:0]            thread_banks [NUM_THREADS];
    logic [NUM_THREADS-1:0] grant;
    logic [31:0]            granted_banks;
    logic [6:0]             grant_cnt;

    logic                   req_hs;
    logic                   rd_hs;
    logic                   last_beat;

    // Dispatcher mapping: bank = (tid + reg + off(tid)) mod 32, where the
    // per-octet offset spreads the four thread groups across the banks.
    function automatic logic [31:0] bank_set(input logic [4:0] tid,
                                             input logic [31:0] bitmap);
        logic [31:0] set;
        logic [4:0]  off;
        logic [4:0]  bank;
        set = '0;
        if (tid < 5'd8)
            off = 5'd0;
        else if (tid < 5'd16)
            off = 5'd16;
        else if (tid < 5'd24)
            off = 5'd8;
        else
            off = 5'd24;
        for (int r = 0; r < 32; r++) begin
            bank = tid + 5'(r) + off;
            if (bitmap[r])
                set[bank] = 1'b1;
        end
        return set;
    endfunction

    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++)
            thread_banks[t] = bank_set(5'(t), reg_bitmap_q);
    end

    // Greedy ascending scan. The lowest pending thread always wins because the
    // accumulated bank set is empty and the count is zero when it is visited.
    always_comb begin
        grant         = '0;
        granted_banks = '0;
        grant_cnt     = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (pending[t] &&
                ((thread_banks[t] & granted_banks) == 32'h0) &&
                (grant_cnt < 7'(MAX_ISSUE))) begin
                grant[t]      = 1'b1;
                granted_banks = granted_banks | thread_banks[t];
                grant_cnt     = grant_cnt + 7'd1;
            end
        end
    end

    assign last_beat      = ((pending & ~grant) == '0);
    assign req_ready      = (state == ST_IDLE);
    assign rd_valid       = (state == ST_SCHED);
    assign busy           = (state == ST_SCHED);
    // pending is cleared whenever the scheduler is idle, so grant and bank
    // outputs are zero there without additional gating.
    assign rd_tmask       = grant;
    assign rd_bank_bitmap = granted_banks;
    assign rd_last        = rd_valid && last_beat;
    assign rd_tag         = tag_q;

    assign req_hs = req_valid && req_ready;
    assign rd_hs  = rd_valid && rd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            pending      <= '0;
            reg_bitmap_q <= '0;
            tag_q        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_hs) begin
                        reg_bitmap_q <= req_reg_bitmap;
                        tag_q        <= req_tag;
                        pending      <= req_tmask;
                        state        <= ST_SCHED;
                    end
                end
                ST_SCHED: begin
                    if (rd_hs) begin
                        pending <= pending & ~grant;
                        if (last_beat)
                            state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pending <= '0;
                end
            endcase
        end
    end

`ifdef BANK_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_beats          <= '0;
            perf_conflict_beats <= '0;
        end else if (rd_hs) begin
            if (perf_beats != 32'hFFFF_FFFF)
                perf_beats <= perf_beats + 32'd1;
            if (!last_beat && (perf_conflict_beats != 32'hFFFF_FFFF))
                perf_conflict_beats <= perf_conflict_beats + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bank_conflict_read_scheduler.sv
// Scoreboard bench: stimulus pushes expected beats, a monitor pops and compares
// on every read handshake. Inputs are driven 1ns after the rising edge, and
// outputs are sampled on the falling edge.
module tb_bank_conflict_read_scheduler;

    localparam int NT = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_reg_bitmap = '0;
    logic [NT-1:0] req_tmask = '0;
    logic [5:0]    req_tag = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic [NT-1:0] rd_tmask;
    logic [31:0]   rd_bank_bitmap;
    logic          rd_last;
    logic [5:0]    rd_tag;
    logic          busy;
`ifdef BANK_SCHED_PERF_EN
    logic [31:0]   perf_beats;
    logic [31:0]   perf_conflict_beats;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] tm;
        logic [31:0] bk;
        logic        last;
        logic [5:0]  tag;
    } exp_t;

    exp_t sb[$];

    bank_conflict_read_scheduler #(.NUM_THREADS(NT), .MAX_ISSUE(8), .TAG_W(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_reg_bitmap (req_reg_bitmap),
        .req_tmask      (req_tmask),
        .req_tag        (req_tag),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_tmask       (rd_tmask),
        .rd_bank_bitmap (rd_bank_bitmap),
        .rd_last        (rd_last),
        .rd_tag         (rd_tag),
`ifdef BANK_SCHED_PERF_EN
        .perf_beats          (perf_beats),
        .perf_conflict_beats (perf_conflict_beats),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] tm, input logic [31:0] bk,
                        input logic last, input logic [5:0] tag);
        exp_t e;
        e.tm = tm; e.bk = bk; e.last = last; e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: compares every read handshake against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rd_valid && rd_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat actual tmask=%h required none", rd_tmask);
                end else begin
                    e = sb.pop_front();
                    chk("beat_tmask", rd_tmask, e.tm);
                    chk("beat_bank",  rd_bank_bitmap, e.bk);
                    chk("beat_last",  32'(rd_last), 32'(e.last));
                    chk("beat_tag",   32'(rd_tag), 32'(e.tag));
                end
            end
        end
    end

    // Issues one request. It returns 1ns after the edge that follows
    // the first-beat latency check.
    task automatic send(input logic [31:0] bm, input logic [NT-1:0] tm, input logic [5:0] tg);
        int n;
        n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_reg_bitmap = bm; req_tmask = tm; req_tag = tg;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL req_accept_timeout actual=no_ready required=ready");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("first_beat_latency", 32'(rd_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL done_timeout actual=busy required=idle");
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    // All 32 banks per thread -> one thread per beat; stalls at beat 2,
    // optionally aborts by reset after beat 2 is consumed.
    task automatic test4(input bit abort);
        rd_ready = 1'b0;
        push(32'h1, 32'hFFFF_FFFF, 1'b0, 6'h04);
        push(32'h2, 32'hFFFF_FFFF, 1'b0, 6'h04);
        if (!abort) begin
            push(32'h4, 32'hFFFF_FFFF, 1'b0, 6'h04);
            push(32'h8, 32'hFFFF_FFFF, 1'b1, 6'h04);
        end
        send(32'hFFFF_FFFF, 32'hF, 6'h04);
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rd_valid), 32'd1);
            chk("stall_tmask", rd_tmask, 32'h2);
            chk("stall_bank",  rd_bank_bitmap, 32'hFFFF_FFFF);
            chk("stall_last",  32'(rd_last), 32'd0);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rd_ready = 1'b1;
        if (abort) begin
            @(posedge clk); #1;
            reset = 1'b1;
            @(negedge clk);
            chk("abort_rd_valid", 32'(rd_valid), 32'd0);
            chk("abort_req_ready", 32'(req_ready), 32'd1);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_rd_last", 32'(rd_last), 32'd0);
            chk("abort_sb_empty", 32'(sb.size()), 32'd0);
            @(posedge clk); #1;
            reset = 1'b0;
        end else begin
            wait_done();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rd_valid",  32'(rd_valid), 32'd0);
        chk("rst_rd_tmask",  rd_tmask, 32'h0);
        chk("rst_rd_bank",   rd_bank_bitmap, 32'h0);
        chk("rst_rd_last",   32'(rd_last), 32'd0);
        chk("rst_rd_tag",    32'(rd_tag), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);

        // 1: eight threads, reg 0 -> banks 0..7, single beat
        push(32'h0000_00FF, 32'h0000_00FF, 1'b1, 6'h01);
        send(32'h1, 32'hFF, 6'h01);
        wait_done();

        // 2: threads 0,1 share bank 1
        push(32'h1, 32'h3, 1'b0, 6'h02);
        push(32'h2, 32'h6, 1'b1, 6'h02);
        send(32'h3, 32'h3, 6'h02);
        wait_done();

        // 4: full run with backpressure
        test4(1'b0);

`ifdef BANK_SCHED_PERF_EN
        chk("perf_beats", perf_beats, 32'd7);
        chk("perf_conflict_beats", perf_conflict_beats, 32'd4);
`endif

        // 3: MAX_ISSUE cap; threads 8..15 land on banks 24..31
        push(32'h0000_00FF, 32'h0000_00FF, 1'b0, 6'h03);
        push(32'h0000_FF00, 32'hFF00_0000, 1'b1, 6'h03);
        send(32'h1, 32'hFFFF, 6'h03);
        wait_done();

        // 5: empty thread mask still completes; stall to observe req_ready low
        rd_ready = 1'b0;
        push(32'h0, 32'h0, 1'b1, 6'h2A);
        send(32'h5, 32'h0, 6'h2A);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("busy_req_ready", 32'(req_ready), 32'd0);
            chk("busy_flag", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        rd_ready = 1'b1;
        wait_done();

        // Empty register bitmap: only the issue cap splits the warp
        push(32'h0000_00FF, 32'h0, 1'b0, 6'h05);
        push(32'h0000_FF00, 32'h0, 1'b0, 6'h05);
        push(32'h00FF_0000, 32'h0, 1'b0, 6'h05);
        push(32'hFF00_0000, 32'h0, 1'b1, 6'h05);
        send(32'h0, 32'hFFFF_FFFF, 6'h05);
        wait_done();

        // Modulo-32 wrap: t0 reg31 -> bank31, t31 reg31 -> (31+31+24)%32 = 22
        push(32'h8000_0001, 32'h8040_0000, 1'b1, 6'h06);
        send(32'h8000_0000, 32'h8000_0001, 6'h06);
        wait_done();

        // Cross-group conflict: t8 and t16 both map reg0 to bank 24
        push(32'h0000_0300, 32'h0300_0000, 1'b0, 6'h07);
        push(32'h0001_0000, 32'h0100_0000, 1'b1, 6'h07);
        send(32'h1, 32'h0001_0300, 6'h07);
        wait_done();

        // 4 again with asynchronous abort, then recovery
        test4(1'b1);
        push(32'h0000_00FF, 32'h0000_00FF, 1'b1, 6'h08);
        send(32'h1, 32'hFF, 6'h08);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
